// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_ILLEGAL  = 2'b10,
      CAUSE_TIMEOUT  = 2'b11
   } lsu_cause_t;

   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      if (is_store) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else          ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                         (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic mis;
      case (f3)
         F3_H, F3_HU: mis = a[0];
         F3_W:        mis = (a != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane extraction with extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        i_is_store,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data
);

   logic [31:0] w_lane;

   assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_store_data;
      if (i_is_store) begin
         case (i_funct3)
            F3_B: begin
               o_be    = 4'b0001 << i_addr_lo;
               o_wdata = {4{i_store_data[7:0]}};
            end
            F3_H: begin
               o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
               o_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      o_load_data = w_lane;
      case (i_funct3)
         F3_B:    o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
         F3_H:    o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
         F3_BU:   o_load_data = {24'd0, w_lane[7:0]};
         F3_HU:   o_load_data = {16'd0, w_lane[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: sequences one memory access per start and reports result or fault.
// state  | meaning
// IDLE   | waiting for start; request inputs sampled here only
// ACCESS | mem_req held with stable address/enables/data until transfer or timeout
// RESP   | one-cycle done pulse with fault status
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_is_store,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_store_data,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_load_data,
   output logic        o_fault,
   output logic [1:0]  o_fault_cause,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ready,
   input  logic [31:0] i_mem_rdata
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   lsu_state_t  r_state;
   lsu_cause_t  r_cause;
   logic [2:0]  r_funct3;
   logic [1:0]  r_addr_lo;
   logic [CW-1:0] r_wait;
   logic        r_done;
   logic        r_fault;
   logic [31:0] r_load_data;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;

   logic        w_idle;
   logic        w_sel_store;
   logic [2:0]  w_sel_f3;
   logic [1:0]  w_sel_lo;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_load;
   logic        w_legal;
   logic        w_mis;
   logic        w_xfer;
   logic        w_timeout;

   // Steering sees live inputs while idle (to build the request) and the latched request otherwise.
   assign w_idle      = (r_state == S_IDLE);
   assign w_sel_store = w_idle ? i_is_store : r_mem_we;
   assign w_sel_f3    = w_idle ? i_funct3   : r_funct3;
   assign w_sel_lo    = w_idle ? i_addr[1:0] : r_addr_lo;

   lsu_align u_align (
      .i_is_store   (w_sel_store),
      .i_funct3     (w_sel_f3),
      .i_addr_lo    (w_sel_lo),
      .i_store_data (i_store_data),
      .i_rdata      (i_mem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load)
   );

   assign w_legal   = f3_legal(i_is_store, i_funct3);
   assign w_mis     = f3_misaligned(i_funct3, i_addr[1:0]);
   assign w_xfer    = r_mem_req && i_mem_ready;
   assign w_timeout = (r_wait == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_cause     <= CAUSE_NONE;
         r_funct3    <= 3'd0;
         r_addr_lo   <= 2'd0;
         r_wait      <= '0;
         r_done      <= 1'b0;
         r_fault     <= 1'b0;
         r_load_data <= 32'd0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_be    <= 4'd0;
         r_mem_wdata <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (!w_legal) begin
                     r_state <= S_RESP;
                     r_done  <= 1'b1;
                     r_fault <= 1'b1;
                     r_cause <= CAUSE_ILLEGAL;
                  end else if (w_mis) begin
                     r_state <= S_RESP;
                     r_done  <= 1'b1;
                     r_fault <= 1'b1;
                     r_cause <= CAUSE_MISALIGN;
                  end else begin
                     r_state     <= S_ACCESS;
                     r_funct3    <= i_funct3;
                     r_addr_lo   <= i_addr[1:0];
                     r_wait      <= '0;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= i_is_store;
                     r_mem_addr  <= {i_addr[31:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                  end
               end
            end
            S_ACCESS: begin
               // A transfer on the timeout edge still completes the access.
               if (w_xfer) begin
                  if (!r_mem_we) r_load_data <= w_load;
                  r_state   <= S_RESP;
                  r_done    <= 1'b1;
                  r_fault   <= 1'b0;
                  r_cause   <= CAUSE_NONE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
               end else if (w_timeout) begin
                  r_state   <= S_RESP;
                  r_done    <= 1'b1;
                  r_fault   <= 1'b1;
                  r_cause   <= CAUSE_TIMEOUT;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy        = !w_idle;
   assign o_done        = r_done;
   assign o_load_data   = r_load_data;
   assign o_fault       = r_fault;
   assign o_fault_cause = r_cause;
   assign o_mem_req     = r_mem_req;
   assign o_mem_we      = r_mem_we;
   assign o_mem_addr    = r_mem_addr;
   assign o_mem_be      = r_mem_be;
   assign o_mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, randomized ops against a byte-level model, reset corner.
module tb_load_store_unit;

   localparam int T = 8;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic        i_is_store;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_store_data;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_load_data;
   logic        o_fault;
   logic [1:0]  o_fault_cause;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_wdata;
   logic        i_mem_ready;
   logic [31:0] i_mem_rdata;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_is_store(i_is_store),
      .i_funct3(i_funct3), .i_addr(i_addr), .i_store_data(i_store_data),
      .o_busy(o_busy), .o_done(o_done), .o_load_data(o_load_data), .o_fault(o_fault),
      .o_fault_cause(o_fault_cause), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
      .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      logic [31:0] rd;
      int          waits;
      logic        e_flt;
      logic [1:0]  e_cause;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic [31:0] e_ld;
      int          e_lat;
   } vec_t;

   // Reference: access size in bytes from funct3, lanes by byte offset, extension by arithmetic.
   function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rd,
                                 output logic flt, output logic [1:0] cause,
                                 output logic [3:0] be, output logic [31:0] wd,
                                 output logic [31:0] ld);
      int nbytes;
      int off;
      bit legal;
      longint v;
      longint mask;
      nbytes = 1 << f3[1:0];
      off    = int'(a % 4);
      legal  = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      flt = 1'b0; cause = 2'b00;
      if (!legal) begin flt = 1'b1; cause = 2'b10; end
      else if ((a % nbytes) != 0) begin flt = 1'b1; cause = 2'b01; end
      be = st ? 4'(((1 << nbytes) - 1) << off) : 4'hf;
      wd = 32'd0;
      for (int i = 0; i < 4; i++) wd = wd | (32'((longint'(sd) >> (8 * (i % nbytes))) & 64'hff) << (8 * i));
      mask = (64'd1 << (8 * nbytes)) - 1;
      v = (longint'(rd) >> (8 * off)) & mask;
      if (!f3[2] && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 1) == 1) v = v - (64'd1 << (8 * nbytes));
      ld = v[31:0];
   endfunction

   task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int waits,
                        output int lat, output logic flt, output logic [1:0] cause,
                        output logic [31:0] ld, output logic [3:0] be, output logic [31:0] wd,
                        output logic [31:0] maddr, output logic we, output logic stable,
                        output logic saw_req);
      int acc;
      bit got;
      @(negedge i_clk);
      i_start = 1'b1; i_is_store = st; i_funct3 = f3; i_addr = a; i_store_data = sd;
      i_mem_rdata = rd; i_mem_ready = 1'($urandom_range(0, 1));
      @(posedge i_clk);
      lat = 1; acc = 0; got = 0; stable = 1'b1; saw_req = 1'b0;
      be = 4'd0; wd = 32'd0; maddr = 32'd0; we = 1'b0;
      while (!got && lat < 4 * T + 8) begin
         #1;
         if (o_done) got = 1;
         else begin
            if (o_mem_req) begin
               if (!saw_req) begin
                  be = o_mem_be; wd = o_mem_wdata; maddr = o_mem_addr; we = o_mem_we;
               end else if (o_mem_be !== be || o_mem_wdata !== wd || o_mem_addr !== maddr || o_mem_we !== we)
                  stable = 1'b0;
               saw_req = 1'b1;
            end
            @(negedge i_clk);
            i_start = 1'($urandom_range(0, 1)); i_is_store = 1'($urandom);
            i_funct3 = 3'($urandom); i_addr = $urandom; i_store_data = $urandom;
            i_mem_ready = o_mem_req && (acc == waits);
            acc += int'(o_mem_req);
            @(posedge i_clk);
            lat++;
         end
      end
      flt = o_fault; cause = o_fault_cause; ld = o_load_data;
      @(negedge i_clk);
      i_start = 1'b0; i_mem_ready = 1'b0;
      @(posedge i_clk);
      #1;
      chk("done_one_cycle", {31'd0, o_done}, 32'd0);
      chk("idle_after_resp", {31'd0, o_busy}, 32'd0);
   endtask

   task automatic check_op(input string tag, input vec_t v);
      int lat;
      logic flt, we, stable, saw_req;
      logic [1:0] cause;
      logic [31:0] ld, wd, maddr;
      logic [3:0] be;
      do_op(v.st, v.f3, v.a, v.sd, v.rd, v.waits, lat, flt, cause, ld, be, wd, maddr, we, stable, saw_req);
      chk({tag, ".latency"}, 32'(lat), 32'(v.e_lat));
      chk({tag, ".fault"}, {31'd0, flt}, {31'd0, v.e_flt});
      chk({tag, ".cause"}, {30'd0, cause}, {30'd0, v.e_cause});
      chk({tag, ".load_data"}, ld, v.e_ld);
      if (v.e_flt && v.e_cause != 2'b11) begin
         chk({tag, ".no_req"}, {31'd0, saw_req}, 32'd0);
      end else begin
         chk({tag, ".mem_addr"}, maddr, {v.a[31:2], 2'b00});
         chk({tag, ".mem_be"}, {28'd0, be}, {28'd0, v.e_be});
         chk({tag, ".mem_we"}, {31'd0, we}, {31'd0, v.st});
         chk({tag, ".stable"}, {31'd0, stable}, 32'd1);
         if (v.st) chk({tag, ".mem_wdata"}, wd, v.e_wd);
      end
   endtask

   vec_t tbl[$];
   vec_t rv;
   logic [31:0] exp_ld;
   logic        m_flt;
   logic [1:0]  m_cause;
   logic [3:0]  m_be;
   logic [31:0] m_wd, m_ld;
   bit          seen_done;

   initial begin
      i_reset = 1'b1; i_start = 1'b0; i_is_store = 1'b0; i_funct3 = 3'd0;
      i_addr = 32'd0; i_store_data = 32'd0; i_mem_ready = 1'b0; i_mem_rdata = 32'd0;

      //     st   f3    addr          sdata          rdata        waits flt  cause be     wdata          load_data      lat
      tbl.push_back('{1'b0, 3'd2, 32'h100, 32'h0,        32'hdeadbeef, 0,   1'b0, 2'd0, 4'hf, 32'h0,        32'hdeadbeef, 2});
      tbl.push_back('{1'b0, 3'd0, 32'h103, 32'h0,        32'h80ffffff, 0,   1'b0, 2'd0, 4'hf, 32'h0,        32'hffffff80, 2});
      tbl.push_back('{1'b0, 3'd4, 32'h103, 32'h0,        32'h80ffffff, 1,   1'b0, 2'd0, 4'hf, 32'h0,        32'h00000080, 3});
      tbl.push_back('{1'b1, 3'd1, 32'h202, 32'h1234abcd, 32'h5555aaaa, 3,   1'b0, 2'd0, 4'hc, 32'habcdabcd, 32'h00000080, 5});
      tbl.push_back('{1'b1, 3'd0, 32'h301, 32'h000000a5, 32'h0,        0,   1'b0, 2'd0, 4'h2, 32'ha5a5a5a5, 32'h00000080, 2});
      tbl.push_back('{1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        0,   1'b1, 2'd1, 4'h0, 32'h0,        32'h00000080, 1});
      tbl.push_back('{1'b1, 3'd4, 32'h100, 32'h0,        32'h0,        0,   1'b1, 2'd2, 4'h0, 32'h0,        32'h00000080, 1});
      tbl.push_back('{1'b0, 3'd7, 32'h101, 32'h0,        32'h0,        0,   1'b1, 2'd2, 4'h0, 32'h0,        32'h00000080, 1});
      tbl.push_back('{1'b0, 3'd2, 32'h400, 32'h0,        32'h11111111, T,   1'b1, 2'd3, 4'hf, 32'h0,        32'h00000080, T + 1});
      tbl.push_back('{1'b0, 3'd5, 32'h402, 32'h0,        32'h9abc1234, T-1, 1'b0, 2'd0, 4'hf, 32'h0,        32'h00009abc, T + 1});
      tbl.push_back('{1'b0, 3'd1, 32'h402, 32'h0,        32'h9abc1234, 2,   1'b0, 2'd0, 4'hf, 32'h0,        32'hffff9abc, 4});

      #12;
      chk("rst.busy", {31'd0, o_busy}, 32'd0);
      chk("rst.done", {31'd0, o_done}, 32'd0);
      chk("rst.fault", {31'd0, o_fault}, 32'd0);
      chk("rst.cause", {30'd0, o_fault_cause}, 32'd0);
      chk("rst.req_we_be", {26'd0, o_mem_req, o_mem_we, o_mem_be}, 32'd0);
      chk("rst.addr", o_mem_addr, 32'd0);
      chk("rst.wdata", o_mem_wdata, 32'd0);
      chk("rst.load_data", o_load_data, 32'd0);
      @(negedge i_clk);
      i_reset = 1'b0;

      foreach (tbl[k]) check_op($sformatf("vec%0d", k), tbl[k]);
      exp_ld = tbl[tbl.size() - 1].e_ld;

      for (int n = 0; n < 40; n++) begin
         rv.st = 1'($urandom);
         rv.f3 = 3'($urandom);
         rv.a  = $urandom;
         rv.sd = $urandom;
         rv.rd = $urandom;
         rv.waits = $urandom_range(0, T);
         model(rv.st, rv.f3, rv.a, rv.sd, rv.rd, m_flt, m_cause, m_be, m_wd, m_ld);
         rv.e_flt = m_flt; rv.e_cause = m_cause; rv.e_be = m_be; rv.e_wd = m_wd;
         if (m_flt) rv.e_lat = 1;
         else if (rv.waits >= T) begin
            rv.e_flt = 1'b1; rv.e_cause = 2'b11; rv.e_lat = T + 1;
         end else begin
            rv.e_lat = rv.waits + 2;
            if (!rv.st) exp_ld = m_ld;
         end
         rv.e_ld = exp_ld;
         check_op($sformatf("rand%0d", n), rv);
      end

      // Reset in the middle of an access: request drops at once and no done follows.
      @(negedge i_clk);
      i_start = 1'b1; i_is_store = 1'b0; i_funct3 = 3'd2; i_addr = 32'h300; i_mem_ready = 1'b0;
      @(posedge i_clk);
      #1;
      chk("midrst.req_before", {31'd0, o_mem_req}, 32'd1);
      @(negedge i_clk);
      i_start = 1'b0;
      @(posedge i_clk);
      #2 i_reset = 1'b1;
      #1;
      chk("midrst.req_async", {31'd0, o_mem_req}, 32'd0);
      chk("midrst.busy_async", {31'd0, o_busy}, 32'd0);
      @(negedge i_clk);
      i_reset = 1'b0;
      i_mem_ready = 1'b1;
      seen_done = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge i_clk);
         #1;
         if (o_done || o_busy) seen_done = 1;
      end
      chk("midrst.no_done", {31'd0, seen_done}, 32'd0);
      chk("midrst.load_data", o_load_data, 32'd0);
      i_mem_ready = 1'b0;
      check_op("after_rst", '{1'b0, 3'd2, 32'h300, 32'h0, 32'hcafef00d, 0, 1'b0, 2'd0, 4'hf, 32'h0, 32'hcafef00d, 2});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle load/store unit for the RISC-V core. It sits between the ALU (address = `rs1 + imm`) and the register-file writeback path. Launched by the control FSM in its memory-access state, it drives a word-addressed memory port with byte enables and a valid/ready handshake. It returns a sign- or zero-extended load result, or reports a fault.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS cycles without `mem_ready` before a timeout fault.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; returns the block to IDLE immediately.
- `start` in 1: launch request from control FSM; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load; sampled with `start`.
- `funct3` in 3: instruction funct3; sampled with `start`.
- `addr` in 32: byte address from the ALU; sampled with `start`.
- `store_data` in 32: rs2 value; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `load_data` out 32: extended load result; held until the next successful load.
- `fault` out 1: valid with `done`; 1 = access not performed or not completed.
- `fault_cause` out 2: valid with `done`. 00 none, 01 misaligned, 10 illegal funct3, 11 timeout.
- `mem_req` out 1: request valid.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: word-aligned address (`{addr[31:2],2'b00}`).
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: memory accepts/returns; a transfer occurs on a rising edge with `mem_req && mem_ready`.
- `mem_rdata` in 32: read data, valid in the transfer cycle.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE, `start`=1:
  - Illegal funct3 or misalignment → RESP with fault.
  - Otherwise latch the request → ACCESS.
- ACCESS:
  - `mem_req`=1, and all `mem_*` outputs are held stable.
  - On transfer: capture and extend the load data (loads only) → RESP with no fault.
  - If the wait counter reaches `TIMEOUT_CYCLES` first: → RESP with cause 11. `load_data` is unchanged.
- RESP: `done`=1 for one cycle → IDLE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other values are illegal.
- Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠0. Illegal funct3 takes priority over misalignment.
- Byte enables and write data:
  - SB: `mem_be` = `4'b0001 << addr[1:0]`; wdata = byte replicated ×4.
  - SH: `mem_be` = `0011` (addr[1]=0) or `1100`; wdata = halfword replicated ×2.
  - SW: `mem_be` = `1111`.
- Loads:
  - `mem_be` = `1111`, `mem_we`=0.
  - Lane = `mem_rdata >> (8*addr[1:0])`.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- Faulted requests never assert `mem_req`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `fault`, `mem_req`, `mem_we` = 0; `fault_cause` = 00; `mem_be` = 0; `mem_addr`, `mem_wdata`, `load_data` = 0; wait counter = 0.
- Fast path: `start` at edge N → ACCESS during cycle N+1. With `mem_ready`=1 at edge N+1, `done` is high during N+1→N+2. Minimum latency is 2 cycles start→done.
- Each wait cycle adds one cycle. The counter increments per ACCESS cycle without transfer. Timeout fires on the edge where the count equals `TIMEOUT_CYCLES`−1 and `mem_ready`=0.
- Fault path: `start` at edge N → `done`+`fault` during cycle N+1.
- `start` while `busy` is ignored; the latched request is not modified.
- `mem_ready` outside ACCESS is ignored.
- `reset` mid-ACCESS: `mem_req` drops asynchronously, and no `done` is issued. A memory write in flight is the memory's responsibility.
- `mem_ready` arriving on the exact timeout edge counts as a transfer; transfer wins.

## Structure
- Package `lsu_pkg`:
  - state enum (IDLE/ACCESS/RESP);
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - fault cause enum.
- Sub-module `lsu_align`: purely combinational. Produces `mem_be` and `mem_wdata` from (funct3, addr[1:0], store_data), and the extended load from (funct3, addr[1:0], rdata). It can be unit-tested alone.
- Top: FSM, request latches, wait counter, `load_data` register.

## Test plan
- LW at 0x100, `mem_rdata`=0xdeadbeef, `mem_ready` high on the first ACCESS cycle → `mem_be`=1111, `done` 2 cycles after `start`, `load_data`=0xdeadbeef, `fault`=0.
- LB / LBU at 0x103, rdata=0x80ffffff → `load_data` = 0xffffff80 for LB, 0x00000080 for LBU.
- SH at 0x202, store_data=0x1234abcd, 3 wait cycles → `mem_addr`=0x200, `mem_be`=1100, `mem_wdata`=0xabcdabcd stable for all 4 ACCESS cycles, `done` at cycle 5.
- LW at 0x101 → `done`+`fault`, cause 01, 1 cycle after `start`, `mem_req` never high. Store with funct3=100 → cause 10.
- `mem_ready` held 0 → `done`, cause 11 after `TIMEOUT_CYCLES`+1 cycles; `load_data` retains its prior value.
- `reset` asserted mid-ACCESS → `mem_req`, `busy` = 0 immediately, no `done`. A fresh LW afterwards completes normally.
